// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registered 8-op bitwise unit with valid/ready handshake; define LOGIC_PIPE_ACC_EN to feed Z back as operand A when ACC=1.
module logic_op_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SELECT,
  input  logic             ACC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             ZERO,
  output logic [15:0]      OP_COUNT
);
  logic [WIDTH-1:0] a_eff, f;
  logic accept;
`ifdef LOGIC_PIPE_ACC_EN
  assign a_eff = ACC ? Z : A;
`else
  logic unused_acc;
  assign unused_acc = ACC;
  assign a_eff = A;
`endif
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign accept = IN_VALID && IN_READY;
  always_comb begin
    case (SELECT)
      3'd0: f = a_eff & B;
      3'd1: f = a_eff | B;
      3'd2: f = a_eff ^ B;
      3'd3: f = ~(a_eff & B);
      3'd4: f = ~(a_eff | B);
      3'd5: f = ~(a_eff ^ B);
      3'd6: f = a_eff;
      default: f = ~a_eff;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Z <= '0;
      ZERO <= 1'b1;
      OUT_VALID <= 1'b0;
      OP_COUNT <= '0;
    end else if (accept) begin
      Z <= f;
      ZERO <= (f == '0);
      OUT_VALID <= 1'b1;
      OP_COUNT <= OP_COUNT + 16'd1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: randomized self-checking bench for logic_op_pipe against a cycle-level reference model.
module tb_logic_op_pipe;
`ifdef LOGIC_PIPE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, acc = 1'b0;
  logic out_valid, out_ready = 1'b1, zero;
  logic [7:0] a = '0, b = '0, z;
  logic [2:0] sel = '0;
  logic [15:0] op_count;
  int n_checks = 0, n_fail = 0;
  logic [7:0] mz;
  logic [15:0] mcnt;
  logic mvalid;

  logic_op_pipe #(.WIDTH(8)) dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .SELECT(sel), .ACC(acc), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .Z(z), .ZERO(zero), .OP_COUNT(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x;
      default: return ~x;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] na, input logic [7:0] nb, input logic [2:0] ns, input logic nacc);
    a = na; b = nb; sel = ns; acc = nacc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mz = op(ns, (ACC_EN && nacc) ? mz : na, nb);
    mcnt = mcnt + 16'd1;
    mvalid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mz = '0; mcnt = '0; mvalid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (z !== 8'h00) begin n_fail++; $display("FAIL reset_z got %h want 00", z); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h want 0000", op_count); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    mz = '0; mcnt = '0; mvalid = 1'b0;
  endtask

  task automatic test_legacy();
    beat(8'd2, 8'd54, 3'b000, 1'b0);
    n_checks++; if (z !== 8'd2 || zero !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL legacy_and got z=%0d zero=%b v=%b want 2 0 1", z, zero, out_valid); end
    beat(8'd2, 8'd14, 3'b001, 1'b0);
    n_checks++; if (z !== 8'd14 || zero !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL legacy_or got z=%0d zero=%b v=%b want 14 0 1", z, zero, out_valid); end
  endtask

  task automatic test_all_codes();
    logic [7:0] tbl [8];
    tbl = '{8'h03, 8'h3F, 8'h3C, 8'hFC, 8'hC0, 8'hC3, 8'h0F, 8'hF0};
    for (int i = 0; i < 8; i++) begin
      beat(8'h0F, 8'h33, 3'(i), 1'b0);
      n_checks++; if (z !== tbl[i]) begin n_fail++; $display("FAIL code_%0d got %h want %h", i, z, tbl[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    beat(8'hAA, 8'hAA, 3'b010, 1'b0);
    out_ready = 1'b0;
    c0 = mcnt;
    a = 8'h5A; b = 8'h0F; sel = 3'b001; acc = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++; if (z !== 8'h00 || zero !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold got z=%h zero=%b rdy=%b want 00 1 0", z, zero, in_ready); end
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
      n_checks++; if (z !== 8'h00 || out_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== c0) begin n_fail++; $display("FAIL bp_stall%0d got z=%h v=%b rdy=%b cnt=%0d want 00 1 0 %0d", i, z, out_valid, in_ready, op_count, c0); end
    end
    a = 8'h5A; b = 8'h0F;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    mz = 8'h5F; mcnt = mcnt + 16'd1;
    n_checks++; if (z !== 8'h5F || op_count !== c0 + 16'd1) begin n_fail++; $display("FAIL bp_release got z=%h cnt=%0d want 5f %0d", z, op_count, c0 + 16'd1); end
  endtask

  task automatic test_accumulate();
    logic [7:0] e1, e2;
    e1 = ACC_EN ? 8'h03 : 8'h02;
    e2 = ACC_EN ? 8'h83 : 8'h80;
    beat(8'h01, 8'h00, 3'b001, 1'b0);
    n_checks++; if (z !== 8'h01) begin n_fail++; $display("FAIL acc_0 got %h want 01", z); end
    beat(8'h00, 8'h02, 3'b001, 1'b1);
    n_checks++; if (z !== e1) begin n_fail++; $display("FAIL acc_1 got %h want %h", z, e1); end
    beat(8'h00, 8'h80, 3'b001, 1'b1);
    n_checks++; if (z !== e2) begin n_fail++; $display("FAIL acc_2 got %h want %h", z, e2); end
  endtask

  task automatic test_random();
    logic rdy;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(3) != 0);
      a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom); acc = 1'($urandom);
      rdy = !mvalid || out_ready;
      #1;
      n_checks++; if (in_ready !== rdy) begin n_fail++; $display("FAIL rnd_ready%0d got %b want %b", i, in_ready, rdy); end
      tick();
      if (in_valid && rdy) begin
        mz = op(sel, (ACC_EN && acc) ? mz : a, b);
        mcnt = mcnt + 16'd1;
        mvalid = 1'b1;
      end else if (out_ready) mvalid = 1'b0;
      n_checks++; if (z !== mz || zero !== (mz == 8'h00) || out_valid !== mvalid || op_count !== mcnt) begin n_fail++; $display("FAIL rnd%0d got z=%h zero=%b v=%b cnt=%0d want %h %b %b %0d", i, z, zero, out_valid, op_count, mz, mz == 8'h00, mvalid, mcnt); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) beat(8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
    out_ready = 1'b0;
    n_checks++; if (op_count !== 16'd7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got cnt=%0d v=%b want 7 1", op_count, out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (z !== 8'h00 || zero !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL mid_async got z=%h zero=%b v=%b cnt=%0d want 00 1 0 0", z, zero, out_valid, op_count); end
    out_ready = 1'b1;
    a = 8'h3C; b = 8'h0F; sel = 3'b000; in_valid = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (op_count !== 16'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset got cnt=%0d v=%b want 0 0", op_count, out_valid); end
    tick();
    in_valid = 1'b0;
    mz = 8'h0C; mcnt = 16'd1; mvalid = 1'b1;
    n_checks++; if (op_count !== 16'd1 || z !== 8'h0C) begin n_fail++; $display("FAIL mid_after got cnt=%0d z=%h want 1 0c", op_count, z); end
  endtask

  task automatic test_wrap();
    int drops = 0;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom); acc = 1'b0;
      if (in_ready !== 1'b1) drops++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL wrap_ready got %0d drops want 0", drops); end
    n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", op_count); end
  endtask

  initial begin
    mz = '0; mcnt = '0; mvalid = 1'b0;
    #1;
    test_reset();
    test_legacy();
    test_all_codes();
    test_backpressure();
    test_accumulate();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
